// File: rtl/popcount_pipe.sv
// Pipelined population counter.
// A balanced adder tree counts the set bits of each input word, with one
// register stage per tree level, followed by an output stage that either
// emits the count directly or accumulates it across a multi-beat packet.
// A single advance signal stalls every stage together when the output is
// held, so bubbles stay in place and ordering is preserved.
module popcount_pipe #(
    parameter int N_IN  = 7,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [N_IN-1:0]  i_data,
    input  logic             i_acc,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [ACC_W-1:0] o_count,
    output logic             o_sat
);

    // Width of a full count and number of tree levels.
    localparam int CW = $clog2(N_IN + 1);
    localparam int D  = (N_IN < 2) ? 1 : $clog2(N_IN);

    if (N_IN < 1) begin : g_nin_check
        $error("popcount_pipe: N_IN must be at least 1");
    end
    if (ACC_W < CW) begin : g_accw_check
        $error("popcount_pipe: ACC_W must be at least clog2(N_IN+1)");
    end

    // One slot per possible node; the spare top slot keeps pair indexing in range.
    typedef logic [N_IN:0][CW-1:0] level_t;

    // Number of live nodes at a given tree level (level 0 = raw input bits).
    function automatic int nodes(input int lvl);
        return (N_IN + (1 << lvl) - 1) >> lvl;
    endfunction

    level_t          lvl_in;
    level_t          lvl_src [D];
    level_t          lvl_q   [1:D];
    logic   [D:1]    v_q;
    logic   [D:1]    a_q;
    logic   [D:1]    l_q;

    logic             adv;
    logic [CW-1:0]    tree_cnt;
    logic [ACC_W:0]   acc_sum;
    logic             overflow;
    logic [ACC_W-1:0] sat_sum;
    logic [ACC_W-1:0] acc_reg;
    logic             sat_flag;

    assign adv     = !o_valid || o_ready;
    assign i_ready = adv;

    // Spread each input bit into its own count-wide leaf node.
    always_comb begin
        lvl_in = '0;
        for (int i = 0; i < N_IN; i++) begin
            lvl_in[i] = CW'(i_data[i]);
        end
    end

    // Source operands for each tree level: the input leaves, then the registered levels.
    always_comb begin
        lvl_src[0] = lvl_in;
        for (int l = 1; l < D; l++) begin
            lvl_src[l] = lvl_q[l];
        end
    end

    // Tree levels: add adjacent pairs, pass an odd leftover straight through.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int l = 0; l < D; l++) begin
                lvl_q[l+1] <= '0;
                for (int j = 0; j < (N_IN + 1) / 2; j++) begin
                    if (j < nodes(l + 1)) begin
                        if (2 * j + 1 < nodes(l)) begin
                            lvl_q[l+1][j] <= lvl_src[l][2*j] + lvl_src[l][2*j+1];
                        end else begin
                            lvl_q[l+1][j] <= lvl_src[l][2*j];
                        end
                    end
                end
            end
        end
    end

    // Valid, accumulate and last flags travel alongside the tree data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            a_q <= '0;
            l_q <= '0;
        end else if (adv) begin
            v_q[1] <= i_valid;
            a_q[1] <= i_acc;
            l_q[1] <= i_last;
            for (int l = 2; l <= D; l++) begin
                v_q[l] <= v_q[l-1];
                a_q[l] <= a_q[l-1];
                l_q[l] <= l_q[l-1];
            end
        end
    end

    assign tree_cnt = lvl_q[D][0];
    assign acc_sum  = {1'b0, acc_reg} + (ACC_W + 1)'(tree_cnt);
    assign overflow = acc_sum[ACC_W];
    assign sat_sum  = overflow ? '1 : acc_sum[ACC_W-1:0];

    // Output stage: emit single counts, or accumulate until the packet's last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid  <= 1'b0;
            o_count  <= '0;
            o_sat    <= 1'b0;
            acc_reg  <= '0;
            sat_flag <= 1'b0;
        end else if (adv) begin
            if (v_q[D]) begin
                if (!a_q[D]) begin
                    o_count <= ACC_W'(tree_cnt);
                    o_sat   <= 1'b0;
                    o_valid <= 1'b1;
                end else if (!l_q[D]) begin
                    acc_reg  <= sat_sum;
                    sat_flag <= sat_flag | overflow;
                    o_valid  <= 1'b0;
                end else begin
                    o_count  <= sat_sum;
                    o_sat    <= sat_flag | overflow;
                    o_valid  <= 1'b1;
                    acc_reg  <= '0;
                    sat_flag <= 1'b0;
                end
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: a 16-bit and a 3-bit accumulator instance share
// one stimulus stream; a scoreboard of bench-computed results is checked
// whenever the output handshake completes.
module tb_popcount_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [6:0]  i_data;
    logic        i_acc;
    logic        i_last;
    logic        o_ready;

    logic        i_ready;
    logic        o_valid;
    logic [15:0] o_count;
    logic        o_sat;

    logic        i_ready3;
    logic        o_valid3;
    logic [2:0]  o_count3;
    logic        o_sat3;

    typedef struct {
        int c16;
        int s16;
        int c3;
        int s3;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   acc16;
    int   acc3;
    bit   sat16;
    bit   sat3;
    int   tests = 0;
    int   fails = 0;
    int   w;

    popcount_pipe #(.N_IN(7), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .i_data(i_data), .i_acc(i_acc), .i_last(i_last),
        .o_valid(o_valid), .o_ready(o_ready), .o_count(o_count), .o_sat(o_sat)
    );

    popcount_pipe #(.N_IN(7), .ACC_W(3)) dut3 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready3),
        .i_data(i_data), .i_acc(i_acc), .i_last(i_last),
        .o_valid(o_valid3), .o_ready(o_ready), .o_count(o_count3), .o_sat(o_sat3)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: compute expected outputs for one accepted beat.
    task automatic model_beat(input logic [6:0] d, input logic a, input logic l);
        int   c;
        int   s16;
        int   s3;
        bit   o16;
        bit   o3;
        exp_t e;
        c = $countones(d);
        if (!a) begin
            e.c16 = c; e.s16 = 0; e.c3 = c; e.s3 = 0;
            sb.push_back(e);
        end else begin
            s16 = acc16 + c; o16 = (s16 > 65535); if (o16) s16 = 65535;
            s3  = acc3 + c;  o3  = (s3 > 7);      if (o3)  s3  = 7;
            if (!l) begin
                acc16 = s16; sat16 = sat16 | o16;
                acc3  = s3;  sat3  = sat3 | o3;
            end else begin
                e.c16 = s16; e.s16 = int'(sat16 | o16);
                e.c3  = s3;  e.s3  = int'(sat3 | o3);
                sb.push_back(e);
                acc16 = 0; sat16 = 0; acc3 = 0; sat3 = 0;
            end
        end
    endtask

    // Drive one beat and hold it until accepted; returns the number of stalled cycles.
    task automatic apply_stimulus(input logic [6:0] d, input logic a, input logic l, output int waits);
        i_valid = 1'b1; i_data = d; i_acc = a; i_last = l;
        waits = 0;
        #1;
        while (i_ready !== 1'b1 && waits < 40) begin
            @(negedge clk); #1;
            waits++;
        end
        if (i_ready !== 1'b1) begin
            check_output("accept_timeout", {31'd0, i_ready}, 32'd1);
        end else begin
            model_beat(d, a, l);
        end
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_output("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: compare each completed output handshake with the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && o_valid === 1'b1 && o_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_output", {31'd0, o_valid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("count16", o_count, mon_e.c16);
                    check_output("sat16", {31'd0, o_sat}, mon_e.s16);
                    check_output("valid3", {31'd0, o_valid3}, 32'd1);
                    check_output("count3", {29'd0, o_count3}, mon_e.c3);
                    check_output("sat3", {31'd0, o_sat3}, mon_e.s3);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] stream [4];
        stream[0] = 7'h00; stream[1] = 7'h01; stream[2] = 7'h55; stream[3] = 7'h7F;
        acc16 = 0; acc3 = 0; sat16 = 0; sat3 = 0;
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_acc = 1'b0; i_last = 1'b0; o_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check_output("reset_valid", {31'd0, o_valid}, 32'd0);
        check_output("reset_count", o_count, 32'd0);
        check_output("reset_sat", {31'd0, o_sat}, 32'd0);
        check_output("reset_ready", {31'd0, i_ready}, 32'd1);
        @(negedge clk);

        // Single beat: result appears exactly four cycles after acceptance, for one cycle.
        apply_stimulus(7'h7F, 1'b0, 1'b0, w);
        #2;
        check_output("lat_c1", {31'd0, o_valid}, 32'd0);
        @(negedge clk); #2;
        check_output("lat_c2", {31'd0, o_valid}, 32'd0);
        @(negedge clk); #2;
        check_output("lat_c3", {31'd0, o_valid}, 32'd0);
        @(negedge clk); #2;
        check_output("lat_c4", {31'd0, o_valid}, 32'd1);
        @(negedge clk); #2;
        check_output("lat_c5", {31'd0, o_valid}, 32'd0);
        drain();

        // Back-to-back stream with no backpressure.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(stream[i], 1'b0, 1'b0, w);
            check_output("stream_ready", w, 0);
        end
        drain();

        // Stream with o_ready low for three cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    apply_stimulus(stream[i % 4], 1'b0, 1'b0, w);
                end
            end
            begin
                repeat (6) @(negedge clk);
                o_ready = 1'b0;
                repeat (3) begin
                    #2;
                    check_output("stall_valid", {31'd0, o_valid}, 32'd1);
                    check_output("stall_ready", {31'd0, i_ready}, 32'd0);
                    check_output("stall_ready3", {31'd0, i_ready3}, 32'd0);
                    check_output("stall_hold", o_count, (sb.size() > 0) ? sb[0].c16 : 32'hDEAD);
                    @(negedge clk);
                end
                o_ready = 1'b1;
            end
        join
        drain();

        // Accumulated packets; second packet checks the accumulator was cleared.
        apply_stimulus(7'h7F, 1'b1, 1'b0, w);
        apply_stimulus(7'h01, 1'b1, 1'b0, w);
        apply_stimulus(7'h00, 1'b1, 1'b1, w);
        apply_stimulus(7'h03, 1'b1, 1'b1, w);
        drain();

        // Single beat inside a packet is emitted alone; packet sum survives it.
        apply_stimulus(7'h01, 1'b1, 1'b0, w);
        apply_stimulus(7'h7F, 1'b0, 1'b0, w);
        apply_stimulus(7'h03, 1'b1, 1'b1, w);
        drain();

        // Saturating packet on the narrow instance, then a plain beat.
        apply_stimulus(7'h7F, 1'b1, 1'b0, w);
        apply_stimulus(7'h7F, 1'b1, 1'b1, w);
        apply_stimulus(7'h01, 1'b0, 1'b0, w);
        drain();

        // Reset with two beats accumulated and a stalled result pending.
        o_ready = 1'b0;
        apply_stimulus(7'h7F, 1'b1, 1'b0, w);
        apply_stimulus(7'h7F, 1'b1, 1'b0, w);
        apply_stimulus(7'h01, 1'b0, 1'b0, w);
        w = 0;
        while (o_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_output("stalled_result_present", {31'd0, o_valid}, 32'd1);
        sb.delete();
        acc16 = 0; acc3 = 0; sat16 = 0; sat3 = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_output("rst_valid", {31'd0, o_valid}, 32'd0);
        check_output("rst_valid3", {31'd0, o_valid3}, 32'd0);
        check_output("rst_count", o_count, 32'd0);
        check_output("rst_sat", {31'd0, o_sat}, 32'd0);
        check_output("rst_ready", {31'd0, i_ready}, 32'd1);
        @(negedge clk);
        o_ready = 1'b1;
        apply_stimulus(7'h0F, 1'b1, 1'b1, w);
        drain();
        repeat (8) @(negedge clk);

        check_output("final_queue_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
